// File: rtl/setup_serializer.sv
// rtl/setup_serializer.sv - parallel-to-serial word transmitter with bit strobe, clock divider and inter-frame gap
module setup_serializer #(
    parameter int DATA_W     = 8,
    parameter int CLK_DIV    = 1,
    parameter int GAP_CYCLES = 0
) (
    input  logic              clk_in,
    input  logic              rst_in,
    input  logic [DATA_W-1:0] data_in,
    input  logic              valid_in,
    output logic              ready_out,
    output logic              serial_out,
    output logic              en_out,
    output logic              busy_out,
    output logic              done_out
);

    // Each counter only has to reach its terminal value (N-1), never N itself.
    localparam int BIT_W = (DATA_W > 1) ? $clog2(DATA_W) : 1;
    localparam int DIV_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam int GAP_W = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;

    localparam logic [BIT_W-1:0] LAST_BIT = BIT_W'(DATA_W - 1);
    localparam logic [DIV_W-1:0] LAST_DIV = DIV_W'(CLK_DIV - 1);
    localparam logic [GAP_W-1:0] LAST_GAP = GAP_W'((GAP_CYCLES > 0) ? GAP_CYCLES - 1 : 0);

    typedef enum logic [1:0] {
        S_IDLE,
        S_SHIFT,
        S_GAP
    } state_t;

    state_t             r_state;
    state_t             w_next;
    logic [DATA_W-1:0]  r_shift;
    logic [BIT_W-1:0]   r_bit;
    logic [DIV_W-1:0]   r_div;
    logic [GAP_W-1:0]   r_gap;
    logic               r_done;

    logic w_accept;
    logic w_bit_end;
    logic w_frame_end;
    logic w_gap_end;

    assign w_accept    = valid_in && (r_state == S_IDLE);
    assign w_bit_end   = (r_state == S_SHIFT) && (r_div == LAST_DIV);
    assign w_frame_end = w_bit_end && (r_bit == LAST_BIT);
    assign w_gap_end   = (r_state == S_GAP) && (r_gap == LAST_GAP);

    // Next-state decode: IDLE -> SHIFT on accept, SHIFT -> GAP/IDLE after the last bit, GAP -> IDLE after the gap.
    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE: begin
                if (w_accept) begin
                    w_next = S_SHIFT;
                end
            end
            S_SHIFT: begin
                if (w_frame_end) begin
                    w_next = (GAP_CYCLES > 0) ? S_GAP : S_IDLE;
                end
            end
            S_GAP: begin
                if (w_gap_end) begin
                    w_next = S_IDLE;
                end
            end
            default: begin
                w_next = S_IDLE;
            end
        endcase
    end

    // State register; reset aborts any frame in progress.
    always_ff @(posedge clk_in) begin
        if (!rst_in) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    // Shift register, bit/divider/gap counters and the completion pulse.
    always_ff @(posedge clk_in) begin
        if (!rst_in) begin
            r_shift <= '0;
            r_bit   <= '0;
            r_div   <= '0;
            r_gap   <= '0;
            r_done  <= 1'b0;
        end else begin
            // Completion is flagged only on a natural return to IDLE, never by reset.
            r_done <= (r_state != S_IDLE) && (w_next == S_IDLE);
            case (r_state)
                S_IDLE: begin
                    if (w_accept) begin
                        r_shift <= data_in;
                        r_bit   <= '0;
                        r_div   <= '0;
                        r_gap   <= '0;
                    end
                end
                S_SHIFT: begin
                    if (w_bit_end) begin
                        r_div   <= '0;
                        r_shift <= r_shift >> 1;
                        r_bit   <= w_frame_end ? '0 : r_bit + 1'b1;
                    end else begin
                        r_div <= r_div + 1'b1;
                    end
                end
                S_GAP: begin
                    r_gap <= w_gap_end ? '0 : r_gap + 1'b1;
                end
                default: begin
                    r_gap <= '0;
                end
            endcase
        end
    end

    // All outputs decode directly from registers, so none of them glitch on input changes.
    assign serial_out = (r_state == S_SHIFT) && r_shift[0];
    assign en_out     = w_bit_end;
    assign done_out   = r_done;
    assign ready_out  = (r_state == S_IDLE);
    assign busy_out   = (r_state != S_IDLE);

endmodule

// File: tb/tb_setup_serializer.sv
// tb/tb_setup_serializer.sv - self-checking bench for setup_serializer over three parameter sets
module tb_setup_serializer;

    logic       clk = 1'b0;
    logic       rst;
    logic       valid;
    logic [7:0] data;
    logic [2:0] rdy, bsy, ser, en, dn;

    always #5 clk = ~clk;

    setup_serializer #(.DATA_W(8), .CLK_DIV(1), .GAP_CYCLES(0)) u0 (
        .clk_in(clk), .rst_in(rst), .data_in(data), .valid_in(valid),
        .ready_out(rdy[0]), .serial_out(ser[0]), .en_out(en[0]), .busy_out(bsy[0]), .done_out(dn[0]));
    setup_serializer #(.DATA_W(8), .CLK_DIV(4), .GAP_CYCLES(0)) u1 (
        .clk_in(clk), .rst_in(rst), .data_in(data), .valid_in(valid),
        .ready_out(rdy[1]), .serial_out(ser[1]), .en_out(en[1]), .busy_out(bsy[1]), .done_out(dn[1]));
    setup_serializer #(.DATA_W(8), .CLK_DIV(1), .GAP_CYCLES(2)) u2 (
        .clk_in(clk), .rst_in(rst), .data_in(data), .valid_in(valid),
        .ready_out(rdy[2]), .serial_out(ser[2]), .en_out(en[2]), .busy_out(bsy[2]), .done_out(dn[2]));

    int         tests = 0;
    int         fails = 0;
    int         cyc = 0;
    bit         started = 0;
    int         t[3] = '{0, 0, 0};
    logic [7:0] word[3] = '{8'h00, 8'h00, 8'h00};
    logic [7:0] rx[3] = '{8'h00, 8'h00, 8'h00};
    int         dacc_prev[3] = '{0, 0, 0};
    int         dacc_last[3] = '{0, 0, 0};
    int         done_cyc[3] = '{0, 0, 0};
    int         ndone[3] = '{0, 0, 0};
    int         nacc[3] = '{0, 0, 0};
    int         nen[3] = '{0, 0, 0};
    int         base_d[3];
    int         base_a[3];

    function automatic int dv(input int i);
        return (i == 1) ? 4 : 1;
    endfunction

    function automatic int gp(input int i);
        return (i == 2) ? 2 : 0;
    endfunction

    // Expected {ready, busy, done, en, serial} for the cycle t after acceptance (t = 0: idle).
    function automatic logic [4:0] expect_out(input int tt, input logic [7:0] w, input int d, input int g);
        int fr;
        fr = 8 * d;
        if (tt >= 1 && tt <= fr)
            return {1'b0, 1'b1, 1'b0, ((tt % d) == 0), w[(tt - 1) / d]};
        if (tt > fr && tt <= fr + g)
            return 5'b01000;
        if (tt == fr + g + 1)
            return 5'b10100;
        return 5'b10000;
    endfunction

    task automatic check(input string name, input int act, input int exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // Model update and far-end receivers on the active edge.
    always @(posedge clk) begin
        for (int i = 0; i < 3; i++) begin
            int last;
            last = 8 * dv(i) + gp(i) + 1;
            if (rst === 1'b1 && valid === 1'b1 && rdy[i] === 1'b1) begin
                dacc_prev[i] = dacc_last[i];
                dacc_last[i] = cyc;
                nacc[i]++;
                nen[i] = 0;
            end
            if (rst === 1'b1 && en[i] === 1'b1) begin
                rx[i] = {ser[i], rx[i][7:1]};
                nen[i]++;
            end
            if (dn[i] === 1'b1) ndone[i]++;
            if (rst !== 1'b1) begin
                t[i] = 0;
                started = 1;
            end else if ((t[i] == 0 || t[i] == last) && valid === 1'b1) begin
                t[i] = 1;
                word[i] = data;
            end else if (t[i] == last) begin
                t[i] = 0;
            end else if (t[i] != 0) begin
                t[i]++;
            end
        end
        cyc++;
    end

    // Every-cycle comparison of all outputs against the model.
    always @(negedge clk) begin
        if (started) begin
            for (int i = 0; i < 3; i++) begin
                logic [4:0] e;
                e = expect_out(t[i], word[i], dv(i), gp(i));
                tests++;
                if ({rdy[i], bsy[i], dn[i], en[i], ser[i]} !== e) begin
                    fails++;
                    $display("FAIL outputs u%0d cyc %0d: got %b expected %b", i, cyc,
                             {rdy[i], bsy[i], dn[i], en[i], ser[i]}, e);
                end
                if (dn[i] === 1'b1) begin
                    done_cyc[i] = cyc;
                    tests++;
                    if (rx[i] !== word[i]) begin
                        fails++;
                        $display("FAIL rx_word u%0d: got %h expected %h", i, rx[i], word[i]);
                    end
                    tests++;
                    if (nen[i] != 8) begin
                        fails++;
                        $display("FAIL en_pulses u%0d: got %0d expected 8", i, nen[i]);
                    end
                end
            end
        end
    end

    task automatic send(input logic [7:0] w);
        @(negedge clk);
        #1 data = w; valid = 1'b1;
        @(negedge clk);
        #1 valid = 1'b0;
    endtask

    task automatic wait_idle();
        for (int k = 0; k < 300; k++) begin
            @(negedge clk);
            if (t[0] == 0 && t[1] == 0 && t[2] == 0) return;
        end
        tests++;
        fails++;
        $display("FAIL idle_timeout: got busy expected idle");
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got no finish expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        // Reset held with a pending word: nothing may start.
        rst = 1'b0; valid = 1'b1; data = 8'hFF;
        @(negedge clk);
        @(negedge clk);
        check("reset_ready", int'(rdy), 7);
        check("reset_busy", int'(bsy), 0);
        check("reset_en", int'(en), 0);
        #1 rst = 1'b1; valid = 1'b0;
        repeat (3) @(negedge clk);
        check("post_reset_ready", int'(rdy), 7);
        check("post_reset_accepts", nacc[0] + nacc[1] + nacc[2], 0);

        // Model pins, hand-derived.
        check("model_a5_t3", int'(expect_out(3, 8'hA5, 1, 0)), 5'b01011);
        check("model_3c_t4", int'(expect_out(4, 8'h3C, 4, 0)), 5'b01010);
        check("model_gap_t9", int'(expect_out(9, 8'h01, 1, 2)), 5'b01000);
        check("model_done_t11", int'(expect_out(11, 8'h01, 1, 2)), 5'b10100);

        // Basic frames.
        send(8'hA5);
        wait_idle();
        check("done_lat_div1", done_cyc[0] - dacc_last[0], 9);
        check("done_lat_div4", done_cyc[1] - dacc_last[1], 33);
        check("done_lat_gap2", done_cyc[2] - dacc_last[2], 11);
        check("rx_a5_u0", int'(rx[0]), 8'hA5);
        send(8'h3C);
        wait_idle();
        check("rx_3c_u1", int'(rx[1]), 8'h3C);

        // Back-to-back with valid held high.
        @(negedge clk);
        #1 data = 8'h01; valid = 1'b1;
        @(negedge clk);
        #1 data = 8'h80;
        repeat (40) @(negedge clk);
        #1 valid = 1'b0;
        wait_idle();
        check("interval_u0", dacc_last[0] - dacc_prev[0], 9);
        check("interval_u1", dacc_last[1] - dacc_prev[1], 33);
        check("interval_u2", dacc_last[2] - dacc_prev[2], 11);
        check("rx_80_u2", int'(rx[2]), 8'h80);

        // Requests while busy are ignored.
        for (int i = 0; i < 3; i++) begin base_d[i] = ndone[i]; base_a[i] = nacc[i]; end
        send(8'hC3);
        repeat (2) @(negedge clk);
        #1 data = 8'h00; valid = 1'b1;
        @(negedge clk);
        #1 valid = 1'b0;
        wait_idle();
        for (int i = 0; i < 3; i++) begin
            check($sformatf("busy_done_u%0d", i), ndone[i] - base_d[i], 1);
            check($sformatf("busy_acc_u%0d", i), nacc[i] - base_a[i], 1);
        end
        check("rx_c3_u0", int'(rx[0]), 8'hC3);

        // Reset after the third strobe of 0xFF.
        for (int i = 0; i < 3; i++) base_d[i] = ndone[i];
        @(negedge clk);
        #1 data = 8'hFF; valid = 1'b1;
        @(negedge clk);
        #1 valid = 1'b0;
        n = (en[0] === 1'b1) ? 1 : 0;
        for (int k = 0; k < 50 && n < 3; k++) begin
            @(negedge clk);
            if (en[0] === 1'b1) n++;
        end
        check("third_strobe_seen", n, 3);
        #1 rst = 1'b0;
        @(negedge clk);
        check("abort_en", int'(en), 0);
        check("abort_serial", int'(ser), 0);
        check("abort_ready", int'(rdy), 7);
        #1 rst = 1'b1;
        repeat (40) @(negedge clk);
        for (int i = 0; i < 3; i++)
            check($sformatf("abort_no_done_u%0d", i), ndone[i] - base_d[i], 0);
        send(8'h55);
        wait_idle();
        for (int i = 0; i < 3; i++)
            check($sformatf("rx_55_u%0d", i), int'(rx[i]), 8'h55);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
